// File: rtl/rs_pkg.sv
// Purpose : shared constants, types and helpers for the reservation-station slot manager.
// Latency : n/a (package).
// Backpr. : n/a (package).
package rs_pkg;

    localparam int RS_NUM_SLOTS_DEFAULT   = 8;
    localparam int RS_ALLOC_WIDTH_DEFAULT = 2;

    // Helpers work on a fixed maximum width so any NUM_SLOTS up to 64 can share them.
    localparam int RS_MAX_SLOTS = 64;
    localparam int RS_MAX_IDX_W = 6;

    typedef logic [$clog2(RS_NUM_SLOTS_DEFAULT)-1:0] slot_idx_t;
    typedef logic [RS_MAX_SLOTS-1:0]                 rs_vec_t;
    typedef logic [RS_MAX_IDX_W:0]                   rs_cnt_t;

    function automatic rs_cnt_t rs_popcount(input rs_vec_t v);
        rs_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < RS_MAX_SLOTS; i++) begin
            cnt = cnt + rs_cnt_t'(v[i]);
        end
        return cnt;
    endfunction

    // Index of the k-th (0-based) clear bit of busy_v, scanning from index 0.
    // Returns 0 when fewer than k+1 free slots exist; callers gate on free count.
    function automatic logic [RS_MAX_IDX_W-1:0] rs_find_kth_free(
        input rs_vec_t busy_v,
        input int      n_slots,
        input int      k
    );
        int                      cnt;
        logic [RS_MAX_IDX_W-1:0] idx;
        cnt = 0;
        idx = '0;
        for (int i = 0; i < RS_MAX_SLOTS; i++) begin
            if ((i < n_slots) && !busy_v[i]) begin
                if (cnt == k) begin
                    idx = RS_MAX_IDX_W'(i);
                end
                cnt = cnt + 1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Purpose : age matrix over RS slots; older[i][j]=1 means slot i was allocated before slot j.
//           Ports: alloc_oh (slots written this cycle), busy (registered occupancy),
//           cand (issue candidates), oldest_oh (oldest candidate, one-hot), flush.
// Latency : oldest_oh combinational from state; matrix updates at the next edge.
// Backpr. : none; the owner decides whether the selected slot is actually freed.
module rs_age_matrix
    import rs_pkg::*;
#(
    parameter int NUM_SLOTS = RS_NUM_SLOTS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NUM_SLOTS-1:0] alloc_oh,
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [NUM_SLOTS-1:0] cand,
    output logic [NUM_SLOTS-1:0] oldest_oh
);

    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] r_older;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] w_older_nxt;

    // A newly allocated column j is younger than every slot already busy and
    // every slot granted to a lower lane this cycle. Lanes take free slots in
    // ascending index order, so "lower lane" is the same as "lower index".
    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (alloc_oh[j]) begin
                    w_older_nxt[i][j] = busy[i] | (alloc_oh[i] && (i < j));
                end else if (alloc_oh[i]) begin
                    w_older_nxt[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_older <= '0;
        end else if (flush) begin
            r_older <= '0;
        end else begin
            r_older <= w_older_nxt;
        end
    end

    // A candidate wins when no other candidate is older than it.
    always_comb begin
        oldest_oh = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            logic w_blocked;
            w_blocked = 1'b0;
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (cand[j] && r_older[j][i]) begin
                    w_blocked = 1'b1;
                end
            end
            oldest_oh[i] = cand[i] & ~w_blocked;
        end
    end

endmodule

// File: rtl/rs_alloc_issue_ctrl.sv
// Purpose : RS slot manager; in-order multi-lane allocation of free slots and
//           oldest-ready issue selection with flush. Ports: alloc_req/gnt/slot,
//           slot_wr, slot_ready, issue_stall/valid/slot, flush, busy + status flags.
// Latency : grants, slot_wr and issue selection same cycle; busy updates one edge later.
// Backpr. : issue_stall holds the selected slot busy; full RS withholds grants.
module rs_alloc_issue_ctrl
    import rs_pkg::*;
#(
    parameter int NUM_SLOTS   = RS_NUM_SLOTS_DEFAULT,
    parameter int ALLOC_WIDTH = RS_ALLOC_WIDTH_DEFAULT,
    parameter int IDX_W       = $clog2(NUM_SLOTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ALLOC_WIDTH-1:0]            alloc_req,
    output logic [ALLOC_WIDTH-1:0]            alloc_gnt,
    output logic [ALLOC_WIDTH-1:0][IDX_W-1:0] alloc_slot,
    output logic [NUM_SLOTS-1:0]              slot_wr,
    input  logic [NUM_SLOTS-1:0]              slot_ready,
    input  logic                              issue_stall,
    output logic                              issue_valid,
    output logic [IDX_W-1:0]                  issue_slot,
    input  logic                              flush,
    output logic [NUM_SLOTS-1:0]              busy,
    output logic [IDX_W:0]                    free_count,
    output logic                              rs_full,
    output logic                              rs_empty
);

    localparam int CNT_W = IDX_W + 1;

    logic [NUM_SLOTS-1:0]              r_busy;
    logic [CNT_W-1:0]                  w_free_count;
    logic [ALLOC_WIDTH-1:0]            w_gnt;
    logic [ALLOC_WIDTH-1:0][IDX_W-1:0] w_slot;
    logic [NUM_SLOTS-1:0]              w_wr;
    logic [RS_MAX_IDX_W-1:0]           w_idx;
    logic                              w_chain;
    logic [NUM_SLOTS-1:0]              w_cand;
    logic [NUM_SLOTS-1:0]              w_oldest;
    logic                              w_issue_valid;
    logic [IDX_W-1:0]                  w_issue_slot;
    logic [NUM_SLOTS-1:0]              w_free_oh;

    assign w_free_count = CNT_W'(NUM_SLOTS) - CNT_W'(rs_popcount(rs_vec_t'(r_busy)));

    // Grant chain: a lane is granted only if every lower lane was granted, so a
    // request gap blocks all higher lanes. Lane k takes the k-th free slot.
    // rst_n is folded in so nothing is written while reset is held.
    always_comb begin
        w_gnt   = '0;
        w_slot  = '0;
        w_wr    = '0;
        w_idx   = '0;
        w_chain = 1'b1;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            w_idx = rs_find_kth_free(rs_vec_t'(r_busy), NUM_SLOTS, k);
            if (w_chain && alloc_req[k] && (int'(w_free_count) > k) && !flush && rst_n) begin
                w_gnt[k]             = 1'b1;
                w_slot[k]            = IDX_W'(w_idx);
                w_wr[IDX_W'(w_idx)]  = 1'b1;
            end
            w_chain = w_gnt[k];
        end
    end

    assign w_cand        = r_busy & slot_ready;
    assign w_issue_valid = (|w_cand) & ~flush & rst_n;

    rs_age_matrix #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alloc_oh  (w_wr),
        .busy      (r_busy),
        .cand      (w_cand),
        .oldest_oh (w_oldest)
    );

    // One-hot to index; w_oldest has at most one bit set.
    always_comb begin
        w_issue_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_oldest[i]) begin
                w_issue_slot = w_issue_slot | IDX_W'(i);
            end
        end
    end

    assign w_free_oh = (w_issue_valid && !issue_stall) ? w_oldest : '0;

    // Allocation only targets non-busy slots, so set and clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_free_oh) | w_wr;
        end
    end

    assign alloc_gnt   = w_gnt;
    assign alloc_slot  = w_slot;
    assign slot_wr     = w_wr;
    assign issue_valid = w_issue_valid;
    assign issue_slot  = w_issue_slot;
    assign busy        = r_busy;
    assign free_count  = w_free_count;
    assign rs_full     = &r_busy;
    assign rs_empty    = ~|r_busy;

endmodule

// File: tb/tb_rs_alloc_issue_ctrl.sv
// Purpose : bench for rs_alloc_issue_ctrl; directed scenarios plus randomized traffic
//           checked every cycle against a queue-based reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_rs_alloc_issue_ctrl;

    localparam int N  = 8;
    localparam int W  = 2;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [W-1:0]         alloc_req;
    logic [W-1:0]         alloc_gnt;
    logic [W-1:0][IW-1:0] alloc_slot;
    logic [N-1:0]         slot_wr;
    logic [N-1:0]         slot_ready;
    logic                 issue_stall;
    logic                 issue_valid;
    logic [IW-1:0]        issue_slot;
    logic                 flush;
    logic [N-1:0]         busy;
    logic [IW:0]          free_count;
    logic                 rs_full;
    logic                 rs_empty;

    int n_cmp = 0;
    int n_err = 0;

    rs_alloc_issue_ctrl #(
        .NUM_SLOTS   (N),
        .ALLOC_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_slot  (alloc_slot),
        .slot_wr     (slot_wr),
        .slot_ready  (slot_ready),
        .issue_stall (issue_stall),
        .issue_valid (issue_valid),
        .issue_slot  (issue_slot),
        .flush       (flush),
        .busy        (busy),
        .free_count  (free_count),
        .rs_full     (rs_full),
        .rs_empty    (rs_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy bits plus a list of busy slots in allocation
    // order (oldest first). The oldest ready slot is the first ready entry.
    bit m_busy[N];
    int m_age[$];

    always @(negedge clk) begin : cmp
        logic [W-1:0]         e_gnt;
        logic [W-1:0][IW-1:0] e_slot;
        logic [N-1:0]         e_wr;
        logic [N-1:0]         e_busy;
        bit                   e_iv;
        int                   e_is;
        int                   e_pos;
        int                   fl[$];
        bit                   prev;

        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_age.delete();
            chk("m_rst_gnt", alloc_gnt, 0);
            chk("m_rst_wr", slot_wr, 0);
            chk("m_rst_iv", issue_valid, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_fc", free_count, N);
        end else begin
            fl.delete();
            e_busy = '0;
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) fl.push_back(i);
                e_busy[i] = m_busy[i];
            end
            e_gnt  = '0;
            e_slot = '0;
            e_wr   = '0;
            prev   = 1'b1;
            for (int k = 0; k < W; k++) begin
                if (prev && alloc_req[k] && (fl.size() > k) && !flush) begin
                    e_gnt[k]     = 1'b1;
                    e_slot[k]    = IW'(fl[k]);
                    e_wr[fl[k]]  = 1'b1;
                end
                prev = e_gnt[k];
            end
            e_iv  = 1'b0;
            e_is  = 0;
            e_pos = -1;
            for (int a = 0; a < m_age.size(); a++) begin
                if (e_pos < 0 && slot_ready[m_age[a]]) begin
                    e_pos = a;
                    e_is  = m_age[a];
                end
            end
            e_iv = (e_pos >= 0) && !flush;

            chk("m_gnt", alloc_gnt, e_gnt);
            chk("m_wr", slot_wr, e_wr);
            for (int k = 0; k < W; k++) begin
                if (e_gnt[k]) chk("m_slot", alloc_slot[k], e_slot[k]);
            end
            chk("m_iv", issue_valid, e_iv);
            if (e_iv) chk("m_islot", issue_slot, e_is);
            chk("m_busy", busy, e_busy);
            chk("m_fc", free_count, fl.size());
            chk("m_full", rs_full, fl.size() == 0);
            chk("m_empty", rs_empty, fl.size() == N);

            // Advance the model to the state after the coming edge.
            if (flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_age.delete();
            end else begin
                if (e_iv && !issue_stall) begin
                    m_busy[e_is] = 1'b0;
                    m_age.delete(e_pos);
                end
                for (int k = 0; k < W; k++) begin
                    if (e_gnt[k]) begin
                        m_busy[e_slot[k]] = 1'b1;
                        m_age.push_back(int'(e_slot[k]));
                    end
                end
            end
        end
    end

    // Apply one cycle of inputs just after the edge; return at the following
    // falling edge with outputs settled.
    task automatic cyc(input logic [W-1:0] req, input logic [N-1:0] rdy,
                       input logic stl, input logic fl);
        @(posedge clk);
        #1;
        alloc_req   = req;
        slot_ready  = rdy;
        issue_stall = stl;
        flush       = fl;
        @(negedge clk);
    endtask

    int exp_seq[3] = '{1, 2, 0};

    initial begin
        rst_n       = 1'b0;
        alloc_req   = 2'b11;
        slot_ready  = '0;
        issue_stall = 1'b0;
        flush       = 1'b0;

        // Reset with requests pending
        @(negedge clk);
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", free_count, 8);
        chk("rst_empty", rs_empty, 1);
        chk("rst_full", rs_full, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        alloc_req = '0;

        // Fill two slots per cycle
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, '0, 1'b0, 1'b0);
            chk("fill_gnt", alloc_gnt, 2'b11);
            chk("fill_s0", alloc_slot[0], 2 * i);
            chk("fill_s1", alloc_slot[1], 2 * i + 1);
        end
        cyc(2'b11, '0, 1'b0, 1'b0);
        chk("full_gnt", alloc_gnt, 0);
        chk("full_flag", rs_full, 1);
        chk("full_fc", free_count, 0);
        cyc(2'b00, '0, 1'b0, 1'b1);
        cyc(2'b00, '0, 1'b0, 1'b0);
        chk("fill_flush_busy", busy, 0);

        // Partial: only one free slot left
        for (int i = 0; i < 3; i++) cyc(2'b11, '0, 1'b0, 1'b0);
        cyc(2'b01, '0, 1'b0, 1'b0);
        cyc(2'b11, '0, 1'b0, 1'b0);
        chk("part_busy", busy, 8'h7F);
        chk("part_gnt", alloc_gnt, 2'b01);
        chk("part_slot", alloc_slot[0], 7);
        chk("part_wr", slot_wr, 8'h80);
        cyc(2'b00, '0, 1'b0, 1'b1);
        cyc(2'b10, '0, 1'b0, 1'b0);
        chk("gap_gnt", alloc_gnt, 0);
        chk("gap_wr", slot_wr, 0);

        // Age order across reallocation
        cyc(2'b11, '0, 1'b0, 1'b0);
        cyc(2'b01, '0, 1'b0, 1'b0);
        chk("age_s2", alloc_slot[0], 2);
        cyc(2'b00, 8'h01, 1'b0, 1'b0);
        chk("age_busy", busy, 8'h07);
        chk("age_iv0", issue_valid, 1);
        chk("age_is0", issue_slot, 0);
        cyc(2'b01, '0, 1'b0, 1'b0);
        chk("age_realloc", alloc_slot[0], 0);
        chk("age_busy2", busy, 8'h06);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 8'hFF, 1'b0, 1'b0);
            chk("age_iv", issue_valid, 1);
            chk("age_seq", issue_slot, exp_seq[i]);
        end
        cyc(2'b00, 8'hFF, 1'b0, 1'b0);
        chk("age_done_iv", issue_valid, 0);
        chk("age_done_empty", rs_empty, 1);

        // Stall holds the selected slot
        cyc(2'b01, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 8'h01, 1'b1, 1'b0);
            chk("stall_iv", issue_valid, 1);
            chk("stall_is", issue_slot, 0);
            chk("stall_busy", busy, 8'h01);
        end
        cyc(2'b00, 8'h01, 1'b0, 1'b0);
        chk("stall_rel_busy", busy, 8'h01);
        cyc(2'b00, '0, 1'b0, 1'b0);
        chk("stall_freed", busy, 0);

        // Flush collides with allocation and issue
        cyc(2'b01, '0, 1'b0, 1'b0);
        cyc(2'b11, 8'h01, 1'b0, 1'b1);
        chk("fl_gnt", alloc_gnt, 0);
        chk("fl_iv", issue_valid, 0);
        chk("fl_wr", slot_wr, 0);
        cyc(2'b00, '0, 1'b0, 1'b0);
        chk("fl_busy", busy, 0);
        chk("fl_fc", free_count, 8);

        // Reset mid-operation
        cyc(2'b11, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        alloc_req = '0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(2'b01, '0, 1'b0, 1'b0);
        chk("post_rst_slot", alloc_slot[0], 0);
        chk("post_rst_gnt", alloc_gnt, 2'b01);

        // Randomized traffic against the model
        repeat (3000) begin
            cyc(W'($urandom()), N'($urandom()), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs_alloc_issue_ctrl.md
# rs_alloc_issue_ctrl

Reservation-station slot manager: owns the per-slot busy state, allocates up to ALLOC_WIDTH free slots per cycle to in-order dispatch lanes, and selects the oldest operand-ready slot for issue using an age matrix. It sits between dispatch and the reservation-station slot array. It drives slot write enables and frees slots on issue. It supersedes the single-allocation, stateless slot chooser by holding busy/age state internally and adding issue selection and flush.

## Interface
- NUM_SLOTS, 8, number of reservation-station slots (≥2)
- ALLOC_WIDTH, 2, dispatch lanes per cycle (1..NUM_SLOTS)
- IDX_W, $clog2(NUM_SLOTS), slot index width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req  in  ALLOC_WIDTH  per-lane dispatch request
- alloc_gnt  out  ALLOC_WIDTH  per-lane grant, same cycle
- alloc_slot  out  ALLOC_WIDTH×IDX_W  slot index per granted lane
- slot_wr  out  NUM_SLOTS  write enable to slot array (OR of granted lanes)
- slot_ready  in  NUM_SLOTS  operands-ready flag from each slot
- issue_stall  in  1  functional unit not accepting
- issue_valid  out  1  a busy, ready slot is selected
- issue_slot  out  IDX_W  selected slot index
- flush  in  1  squash all slots
- busy  out  NUM_SLOTS  registered occupancy
- free_count  out  IDX_W+1  number of non-busy slots
- rs_full, rs_empty  out  1  status flags

## Operation
- State: busy[NUM_SLOTS] plus an age matrix older[i][j]. older[i][j]=1 means slot i was allocated before slot j.
- Allocation uses only registered busy. A slot freed this cycle is not reusable until the next cycle.
- Grant chain: alloc_gnt[k] = alloc_req[k] & (k==0 | alloc_gnt[k-1]) & (free_count > k) & !flush.
  - Lanes are granted strictly in order. A gap in requests blocks all higher lanes.
- Lane k receives the k-th lowest-index free slot. slot_wr carries a one-hot for each granted slot.
- On allocating slot s:
  - busy[s] ← 1.
  - older[s][*] ← 0.
  - older[j][s] ← 1 for every j busy before this cycle, and for every slot granted to a lower lane this cycle.
- Issue candidates: cand = busy & slot_ready.
  - Slot i is selected if cand[i] and no cand[j] has older[j][i].
  - Exactly one slot matches when cand ≠ 0.
  - issue_valid = |cand & !flush.
- Free: when issue_valid & !issue_stall, busy[issue_slot] ← 0 at the edge. Its age row and column are don't-care until reallocation.
- While issue_stall=1, issue_slot may change only if older or newly ready slots appear. The bench checks the stable case only.
- Flush: at the edge, busy ← 0 and older ← 0. In the flush cycle, alloc_gnt=0, slot_wr=0 and issue_valid=0. Flush has priority over everything.
- A slot can be issued and a different slot allocated in the same cycle. Both updates take effect at the same edge.
- Status flags: rs_full = &busy, rs_empty = ~|busy, free_count = NUM_SLOTS − popcount(busy).

## Timing
- Grant, slot_wr and issue selection are combinational from registered state and same-cycle inputs. Busy changes one edge later.
- Latency: allocated slot visible in busy after 1 edge, and issuable from the next cycle if ready.
- Reset (asynchronous, rst_n=0):
  - busy=0, older=0, free_count=NUM_SLOTS, rs_empty=1, rs_full=0.
  - alloc_gnt, slot_wr and issue_valid are forced to 0 while reset is asserted.
- Reset asserted mid-operation discards all occupancy immediately. The first allocation after release goes to slot 0.

## Structure
- Shared package rs_pkg:
  - RS_NUM_SLOTS_DEFAULT and RS_ALLOC_WIDTH_DEFAULT.
  - slot_idx_t typedef.
  - Popcount and find-k-th-free helper functions.
- One sub-module, rs_age_matrix (NUM_SLOTS):
  - Holds older[][].
  - Takes allocation one-hot plus busy vector.
  - Outputs the oldest-of-candidates one-hot.
- Top level holds the busy register, the grant chain and one-hot→index encoding.

## Test plan
- Reset: drive rst_n=0 with alloc_req=11 → alloc_gnt=00, busy=0, free_count=8, rs_empty=1.
- Fill: alloc_req=11 for 5 cycles, no ready → grants {0,1},{2,3},{4,5},{6,7}, then 00. rs_full=1 after the 4th edge.
- Partial: busy=0x7F, alloc_req=11 → alloc_gnt=01, alloc_slot[0]=7. Lane-gap alloc_req=10 on an empty RS → alloc_gnt=00.
- Age order:
  - Allocate slots 0,1, then slot 2.
  - Issue slot 0 (only 0 ready).
  - Reallocate slot 0.
  - Set all ready → issue sequence 1, 2, 0.
- Stall: one ready slot, issue_stall=1 for 3 cycles → issue_valid=1, same issue_slot, busy unchanged. On release, busy bit clears after 1 edge.
- Flush collision: flush=1 with alloc_req=11 and a ready slot → alloc_gnt=00, issue_valid=0. Next cycle busy=0, free_count=8.
